// File: rtl/ysyx_22041752_div_pkg.sv
// Shared definitions for the EXE-stage iterative divider.
package ysyx_22041752_div_pkg;

    // Register-file data width (RV64).
    localparam int RF_DATA_WD = 64;

    // Divider control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/ysyx_22041752_aser.sv
// Adder/subtractor: s = a + b (sub=0) or a - b (sub=1).
// On subtract, cout=1 means a >= b (no borrow).
module ysyx_22041752_aser #(
    parameter int WD = 64
) (
    input  logic [WD-1:0] a,
    input  logic [WD-1:0] b,
    input  logic          sub,
    output logic [WD-1:0] s,
    output logic          cout
);

    logic [WD:0] sum;

    // Subtraction is a + ~b + 1; the carry-in is the sub flag itself.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WD{1'b0}}, sub};
        s    = sum[WD-1:0];
        cout = sum[WD];
    end

endmodule

// File: rtl/ysyx_22041752_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Handshake: EXE holds div_valid and stable operands until out_valid pulses;
// out_valid is a single-cycle pulse in DONE, and the op is abandoned if
// flush rises or div_valid drops before then.
module ysyx_22041752_div
    import ysyx_22041752_div_pkg::*;
#(
    parameter int WD = RF_DATA_WD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          div_valid,
    input  logic          div_u,
    input  logic          div_rem,
    input  logic [WD-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic [WD-1:0] result,
    output logic          out_valid
);

    localparam int CW = $clog2(WD);
    localparam logic [WD-1:0] MIN_VAL = {1'b1, {(WD-1){1'b0}}};

    div_state_e    state, state_nxt;
    logic [CW-1:0] count;
    logic [WD-1:0] rem, quo, dsor;
    logic          q_neg, r_neg;

    logic          start, abort, is_zero, is_ovf;
    logic [WD-1:0] rem_sh, quo_sh, trial;
    logic          no_borrow, take;

    function automatic logic [WD-1:0] neg(input logic [WD-1:0] x);
        return ~x + WD'(1);
    endfunction

    // Request decode and special-case detection.
    always_comb begin
        start   = (state == ST_IDLE) & div_valid & ~flush;
        abort   = flush | ~div_valid;
        is_zero = (divisor == '0);
        is_ovf  = ~div_u & (dividend == MIN_VAL) & (divisor == '1);
    end

    // One iteration: shift {rem,quo} left, trial-subtract the divisor.
    // The bit shifted out of rem is kept: if set, the shifted remainder
    // exceeds any WD-bit divisor, so the subtraction must be taken.
    always_comb begin
        rem_sh = {rem[WD-2:0], quo[WD-1]};
        quo_sh = {quo[WD-2:0], 1'b0};
        take   = rem[WD-1] | no_borrow;
    end

    ysyx_22041752_aser #(.WD(WD)) u_aser (
        .a    (rem_sh),
        .b    (dsor),
        .sub  (1'b1),
        .s    (trial),
        .cout (no_borrow)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (is_zero | is_ovf) ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (abort)                    state_nxt = ST_IDLE;
                else if (count == CW'(WD-1))  state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = abort ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dsor   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    count <= '0;
                    if (is_zero) begin
                        result <= div_rem ? dividend : '1;
                    end else if (is_ovf) begin
                        result <= div_rem ? '0 : MIN_VAL;
                    end else begin
                        rem   <= '0;
                        quo   <= (~div_u & dividend[WD-1]) ? neg(dividend) : dividend;
                        dsor  <= (~div_u & divisor[WD-1])  ? neg(divisor)  : divisor;
                        q_neg <= ~div_u & (dividend[WD-1] ^ divisor[WD-1]);
                        r_neg <= ~div_u & dividend[WD-1];
                    end
                end
                ST_CALC: if (!abort) begin
                    rem   <= take ? trial : rem_sh;
                    quo   <= {quo_sh[WD-1:1], take};
                    count <= count + CW'(1);
                end
                ST_FIX: if (!abort) begin
                    result <= div_rem ? (r_neg ? neg(rem) : rem)
                                      : (q_neg ? neg(quo) : quo);
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == ST_DONE) & ~flush & div_valid;

endmodule

// File: tb/tb_ysyx_22041752_div.sv
// Directed and randomized test of the iterative divider against an
// arithmetic reference model.
module tb_ysyx_22041752_div;

    localparam logic [63:0] MIN_VAL = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset, flush, div_valid, div_u, div_rem;
    logic [63:0] dividend, divisor, result;
    logic        out_valid;

    int passed = 0;
    int total  = 0;
    logic [63:0] last_res;

    ysyx_22041752_div dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .div_valid (div_valid),
        .div_u     (div_u),
        .div_rem   (div_rem),
        .dividend  (dividend),
        .divisor   (divisor),
        .result    (result),
        .out_valid (out_valid)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // Reference model: RISC-V division semantics in plain arithmetic.
    function automatic logic [63:0] model_res(input logic [63:0] a, input logic [63:0] b,
                                              input logic u, input logic r);
        if (b == 64'd0)                            return r ? a : '1;
        if (!u && a == MIN_VAL && b == '1)         return r ? 64'd0 : MIN_VAL;
        if (u)                                     return r ? (a % b) : (a / b);
        return r ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    endfunction

    function automatic int model_lat(input logic [63:0] a, input logic [63:0] b, input logic u);
        if (b == 64'd0 || (!u && a == MIN_VAL && b == '1)) return 1;
        return 66;
    endfunction

    // Drive one operation, wait for out_valid (bounded), check result,
    // latency and single-cycle pulse; then drop div_valid.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic u, input logic r);
        logic [63:0] exp;
        int lat;
        bit seen;
        exp = model_res(a, b, u, r);
        @(negedge clk);
        dividend = a; divisor = b; div_u = u; div_rem = r; div_valid = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_res"}, result, exp);
        check({tag, "_lat"}, 64'(lat), 64'(model_lat(a, b, u)));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(out_valid), 64'd0);
        div_valid = 1'b0;
        last_res = exp;
    endtask

    initial begin
        int hits;
        logic [63:0] ra, rb;
        logic ru, rr;

        reset = 1'b1; flush = 1'b0; div_valid = 1'b0; div_u = 1'b0; div_rem = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        last_res = '0;

        // Directed cases.
        run_op("divu_100_7", 64'd100, 64'd7, 1'b1, 1'b0);
        run_op("remu_100_7", 64'd100, 64'd7, 1'b1, 1'b1);
        run_op("div_m7_2",   -64'sd7, 64'd2, 1'b0, 1'b0);
        run_op("rem_m7_2",   -64'sd7, 64'd2, 1'b0, 1'b1);
        run_op("div_7_m2",   64'd7, -64'sd2, 1'b0, 1'b0);
        run_op("rem_7_m2",   64'd7, -64'sd2, 1'b0, 1'b1);
        run_op("div_by0",    64'h1234, 64'd0, 1'b0, 1'b0);
        run_op("rem_by0",    64'h1234, 64'd0, 1'b0, 1'b1);
        run_op("div_ovf",    MIN_VAL, '1, 1'b0, 1'b0);
        run_op("rem_ovf",    MIN_VAL, '1, 1'b0, 1'b1);
        run_op("divu_min_m1", MIN_VAL, '1, 1'b1, 1'b0);
        run_op("divu_bigdsor", '1, 64'h8000_0000_0000_0001, 1'b1, 1'b1);

        // Flush at CALC count 30: no completion, result unchanged.
        @(negedge clk);
        dividend = 64'd1000; divisor = 64'd3; div_u = 1'b1; div_rem = 1'b0; div_valid = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        flush = 1'b1; div_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        hits = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check("flush_no_valid", 64'(hits), 64'd0);
        check("flush_result", result, last_res);
        run_op("after_flush", 64'd9, 64'd3, 1'b1, 1'b0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        dividend = 64'd12345; divisor = 64'd7; div_u = 1'b0; div_rem = 1'b0; div_valid = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_result", result, 64'd0);
        div_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_res = '0;

        // Back-to-back with one idle cycle between.
        run_op("b2b_a", 64'd1_000_000, 64'd37, 1'b0, 1'b1);
        @(posedge clk);
        run_op("b2b_b", -64'sd1_000_000, 64'd37, 1'b0, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 16; n++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = {$urandom, $urandom};
                1: rb = 64'($urandom_range(1, 1000));
                2: rb = 64'd0;
                3: rb = -64'($urandom_range(1, 1000));
                default: rb = {32'd0, $urandom};
            endcase
            if ($urandom_range(0, 7) == 0) begin ra = MIN_VAL; rb = '1; end
            ru = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", n), ra, rb, ru, rr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
